// File: rtl/avalon_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM RAM between the instruction-fetch
// port (m0, read-only) and the load/store port (m1), with a stuck-slave watchdog.
module avalon_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter bit          RR_INIT        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_read,
    input  logic [31:0] m0_address,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [3:0]  m1_byteenable,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_writedata,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,
    output logic        s_read,
    output logic        s_write,
    output logic [3:0]  s_byteenable,
    output logic [31:0] s_address,
    output logic [31:0] s_writedata,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,
    output logic        grant_owner,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        r_state;
    logic          r_owner;
    logic          r_last;
    logic          r_op_wr;
    logic          r_s_read;
    logic          r_s_write;
    logic [3:0]    r_be;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_wd_cnt;
    logic          r_timeout;

    logic w_m0_req;
    logic w_m1_req;
    logic w_pick;
    logic w_wr;
    logic w_done;

    assign w_m0_req = m0_read;
    assign w_m1_req = m1_read | m1_write;
    // On a tie the master that did not win last time goes next.
    assign w_pick   = (w_m0_req && w_m1_req) ? ~r_last : w_m1_req;
    // m1 asserting read and write together is served as a write.
    assign w_wr     = w_pick & m1_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_last    <= RR_INIT;
            r_op_wr   <= 1'b0;
            r_s_read  <= 1'b0;
            r_s_write <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_m0_req || w_m1_req) begin
                        r_owner   <= w_pick;
                        r_last    <= w_pick;
                        r_op_wr   <= w_wr;
                        r_s_read  <= ~w_wr;
                        r_s_write <= w_wr;
                        r_addr    <= w_pick ? m1_address : m0_address;
                        r_wdata   <= w_pick ? m1_writedata : 32'h0;
                        r_be      <= w_pick ? m1_byteenable : 4'hF;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!s_waitrequest) begin
                        r_s_read  <= 1'b0;
                        r_s_write <= 1'b0;
                        r_wd_cnt  <= '0;
                        r_state   <= r_op_wr ? IDLE : RESP;
                    end else if (r_wd_cnt == WD_LAST) begin
                        // Flag only; the transfer keeps waiting on the slave.
                        r_timeout <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Writes complete in the accept cycle; reads one cycle later with RAM data.
    assign w_done = ((r_state == ISSUE) && !s_waitrequest && r_op_wr) || (r_state == RESP);

    assign m0_waitrequest = ~(w_done && !r_owner);
    assign m1_waitrequest = ~(w_done &&  r_owner);
    assign m0_readdata    = ((r_state == RESP) && !r_owner) ? s_readdata : 32'h0;
    assign m1_readdata    = ((r_state == RESP) &&  r_owner) ? s_readdata : 32'h0;

    assign s_read       = r_s_read;
    assign s_write      = r_s_write;
    assign s_byteenable = r_be;
    assign s_address    = r_addr;
    assign s_writedata  = r_wdata;
    assign grant_owner  = r_owner;
    assign busy         = (r_state != IDLE);
    assign timeout_err  = r_timeout;
endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Bench for avalon_mem_arbiter: directed vector table, round-robin, watchdog,
// mid-transfer reset, then random traffic against a byte-lane memory model.
module tb_avalon_mem_arbiter;
    localparam int TO = 16;
    localparam int N  = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_read = 1'b0;
    logic [31:0] m0_address = '0;
    logic [31:0] m0_readdata;
    logic        m0_waitrequest;
    logic        m1_read = 1'b0;
    logic        m1_write = 1'b0;
    logic [3:0]  m1_byteenable = '0;
    logic [31:0] m1_address = '0;
    logic [31:0] m1_writedata = '0;
    logic [31:0] m1_readdata;
    logic        m1_waitrequest;
    logic        s_read;
    logic        s_write;
    logic [3:0]  s_byteenable;
    logic [31:0] s_address;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata = '0;
    logic        s_waitrequest;
    logic        grant_owner;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    avalon_mem_arbiter #(.TIMEOUT_CYCLES(TO), .RR_INIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_address(m0_address), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest),
        .m1_read(m1_read), .m1_write(m1_write), .m1_byteenable(m1_byteenable),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .s_read(s_read), .s_write(s_write), .s_byteenable(s_byteenable),
        .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
        .s_waitrequest(s_waitrequest),
        .grant_owner(grant_owner), .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'hBFC00000: return 32'h3C011234;
            32'hBFC00010: return 32'h11223344;
            default:      return a ^ 32'hA5A50000;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // RAM slave: data one cycle after acceptance, programmable wait states.
    bit [31:0]   ram [bit [29:0]];
    int          wait_left = 0;
    int          wait_cfg = 0;
    bit          rand_waits = 1'b0;
    bit          force_wait = 1'b0;
    logic [29:0] rk;
    logic [31:0] rcur;

    assign s_waitrequest = force_wait || ((s_read || s_write) && wait_left != 0);

    always @(posedge clk) begin
        if ((s_read || s_write) && !s_waitrequest) begin
            rk   = s_address[31:2];
            rcur = ram.exists(rk) ? ram[rk] : init_word({rk, 2'b00});
            if (s_write) ram[rk] = merge(rcur, s_writedata, s_byteenable);
            else         s_readdata <= rcur;
        end
        if (!(s_read || s_write))
            wait_left <= rand_waits ? int'($urandom_range(0, 3)) : wait_cfg;
        else if (s_waitrequest && wait_left != 0)
            wait_left <= wait_left - 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk(nm, 160'({s_read, s_write, s_byteenable, s_address, s_writedata,
                      m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
                      grant_owner, busy, timeout_err}),
            160'({2'b00, 4'h0, 64'h0, 2'b11, 64'h0, 3'b000}));
    endtask

    typedef struct {
        string       name;
        bit          mst;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
    } vec_t;

    task automatic drop_all();
        m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    // Single transfer from IDLE; latency counts the request cycle as cycle 1.
    task automatic do_xfer(input vec_t v);
        int n;
        logic [3:0] be_seen;
        bit ok;
        wait_cfg = v.waits;
        @(posedge clk); #1;
        if (!v.mst) begin
            m0_read = 1'b1; m0_address = v.addr;
        end else begin
            m1_read = v.rd; m1_write = v.wr; m1_address = v.addr;
            m1_writedata = v.wdata; m1_byteenable = v.be;
        end
        n = 0; be_seen = '0; ok = 1'b0;
        while (!ok && n < 60) begin
            @(negedge clk);
            n++;
            if (s_read || s_write) be_seen = s_byteenable;
            if ((v.mst ? m1_waitrequest : m0_waitrequest) == 1'b0) begin
                ok = 1'b1;
                chk({v.name, "_lat"}, 160'(n), 160'(v.exp_lat));
                chk({v.name, "_be"}, 160'(be_seen), 160'(v.exp_be));
                if (!v.wr)
                    chk({v.name, "_data"}, 160'(v.mst ? m1_readdata : m0_readdata),
                        160'(v.exp_rdata));
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no completion after %0d cycles", v.name, n);
        end
        @(posedge clk); #1;
        drop_all();
    endtask

    bit [31:0]   ref_mem [bit [29:0]];
    vec_t        vecs [8];

    initial begin
        int          n, k, who;
        bit          ok;
        bit          act [2];
        int          op [2];
        int          gap [2];
        int          done [2];
        int          issued [2];
        logic [31:0] raddr [2];
        logic [31:0] rdata [2];
        logic [3:0]  rbe [2];
        logic        pv_strobe, pv_wait;
        logic [69:0] pv_bus;
        logic [31:0] expd;
        vec_t        v;

        vecs[0] = '{"m0_boot",   1'b0, 1'b1, 1'b0, 32'hBFC00000, 32'h0,        4'hF, 0, 3, 32'h3C011234, 4'hF};
        vecs[1] = '{"m1_wr_half",1'b1, 1'b0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'h3, 0, 2, 32'h0,        4'h3};
        vecs[2] = '{"m1_rd_half",1'b1, 1'b1, 1'b0, 32'hBFC00010, 32'h0,        4'hF, 0, 3, 32'h1122BEEF, 4'hF};
        vecs[3] = '{"m1_rdwr",   1'b1, 1'b1, 1'b1, 32'h00000100, 32'hCAFEF00D, 4'hF, 0, 2, 32'h0,        4'hF};
        vecs[4] = '{"m1_rd_w2",  1'b1, 1'b1, 1'b0, 32'h00000100, 32'h0,        4'hF, 2, 5, 32'hCAFEF00D, 4'hF};
        vecs[5] = '{"m1_wr_w3",  1'b1, 1'b0, 1'b1, 32'h00000100, 32'hAABBCCDD, 4'h8, 3, 5, 32'h0,        4'h8};
        vecs[6] = '{"m0_rd_w1",  1'b0, 1'b1, 1'b0, 32'h00000100, 32'h0,        4'hF, 1, 4, 32'hAAFEF00D, 4'hF};
        vecs[7] = '{"m1_rd_be5", 1'b1, 1'b1, 1'b0, 32'h00000104, 32'h0,        4'h5, 0, 3, 32'hA5A50104, 4'h5};

        // Reset values
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset_vals");
        @(negedge clk) reset = 1'b1;

        foreach (vecs[i]) do_xfer(vecs[i]);

        // Round-robin with both masters requesting continuously after reset
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        wait_cfg = 0;
        @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 32'h3000;
        m1_read = 1'b1; m1_address = 32'h3004; m1_byteenable = 4'hF;
        k = 0;
        for (int cyc = 0; cyc < 100 && k < 8; cyc++) begin
            @(negedge clk);
            if (!m0_waitrequest || !m1_waitrequest) begin
                who = m0_waitrequest ? 1 : 0;
                chk($sformatf("rr_who_%0d", k), 160'(who), 160'(k % 2));
                chk($sformatf("rr_owner_%0d", k), 160'(grant_owner), 160'(k % 2));
                k++;
            end
        end
        chk("rr_count", 160'(k), 160'(8));
        @(posedge clk); #1;
        drop_all();

        // Watchdog: slave stalls for exactly TO cycles of ISSUE
        force_wait = 1'b1; wait_cfg = 0;
        @(posedge clk); #1;
        m1_write = 1'b1; m1_read = 1'b0; m1_address = 32'h300;
        m1_writedata = 32'h12345678; m1_byteenable = 4'hF;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < TO; cyc++) begin
            @(negedge clk);
            if (s_write && s_waitrequest) n++;
        end
        chk("wd_wait_cycles", 160'(n), 160'(TO));
        chk("wd_not_early", 160'(timeout_err), 160'(0));
        @(posedge clk); #1;
        chk("wd_set", 160'(timeout_err), 160'(1));
        force_wait = 1'b0;
        @(negedge clk);
        chk("wd_completes", 160'(m1_waitrequest), 160'(0));
        @(posedge clk); #1;
        drop_all();
        repeat (3) @(posedge clk);
        #1 chk("wd_sticky", 160'(timeout_err), 160'(1));
        v = '{"wd_readback", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 0, 3, 32'h12345678, 4'hF};
        do_xfer(v);

        // Reset during the ISSUE phase of a read
        wait_cfg = 4;
        @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 32'hBFC00000;
        ok = 1'b0;
        for (int cyc = 0; cyc < 10 && !ok; cyc++) begin
            @(negedge clk);
            ok = s_read;
        end
        chk("mid_reset_in_issue", 160'(ok), 160'(1));
        reset = 1'b0;
        #1 chk_reset_vals("mid_reset_vals");
        m0_read = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_reset_no_done", 160'({m0_waitrequest, m1_waitrequest}), 160'(2'b11));
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", 160'({m0_waitrequest, m1_waitrequest, busy}), 160'(3'b110));
        end
        v = '{"post_reset_rd", 1'b0, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'hF, 0, 3, 32'h3C011234, 4'hF};
        do_xfer(v);

        // Random traffic from both masters with random RAM wait states
        rand_waits = 1'b1;
        pv_strobe = 1'b0; pv_wait = 1'b0; pv_bus = '0;
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0; op[m] = 0; gap[m] = 0; done[m] = 0; issued[m] = 0;
            raddr[m] = '0; rdata[m] = '0; rbe[m] = '0;
        end
        for (int cyc = 0; cyc < 3000 && (done[0] < N || done[1] < N); cyc++) begin
            @(negedge clk);
            if (pv_strobe && pv_wait)
                chk("rnd_bus_stable", 160'({s_read, s_write, s_byteenable, s_address, s_writedata}),
                    160'(pv_bus));
            pv_strobe = s_read || s_write;
            pv_wait   = s_waitrequest;
            pv_bus    = {s_read, s_write, s_byteenable, s_address, s_writedata};
            for (int m = 0; m < 2; m++) begin
                if (act[m]) begin
                    if ((m == 1 ? m1_waitrequest : m0_waitrequest) == 1'b0) begin
                        chk($sformatf("rnd_excl_m%0d", m),
                            160'(m == 1 ? m0_waitrequest : m1_waitrequest), 160'(1));
                        if (op[m] == 0) begin
                            expd = ref_mem.exists(raddr[m][31:2]) ? ref_mem[raddr[m][31:2]]
                                                                  : init_word(raddr[m]);
                            chk($sformatf("rnd_rdata_m%0d", m),
                                160'(m == 1 ? m1_readdata : m0_readdata), 160'(expd));
                        end else begin
                            expd = ref_mem.exists(raddr[m][31:2]) ? ref_mem[raddr[m][31:2]]
                                                                  : init_word(raddr[m]);
                            ref_mem[raddr[m][31:2]] = merge(expd, rdata[m], rbe[m]);
                        end
                        done[m]++;
                        act[m] = 1'b0;
                        gap[m] = int'($urandom_range(0, 2));
                    end
                end else begin
                    chk($sformatf("rnd_no_spurious_m%0d", m),
                        160'(m == 1 ? m1_waitrequest : m0_waitrequest), 160'(1));
                    if (issued[m] < N) begin
                        if (gap[m] == 0) begin
                            act[m]   = 1'b1;
                            op[m]    = (m == 1) ? int'($urandom_range(0, 2)) : 0;
                            raddr[m] = 32'h2000 + ($urandom_range(0, 7) << 2);
                            rdata[m] = $urandom;
                            rbe[m]   = (m == 1) ? 4'($urandom_range(1, 15)) : 4'hF;
                            issued[m]++;
                        end else begin
                            gap[m]--;
                        end
                    end
                end
            end
            @(posedge clk); #1;
            m0_read       = act[0];
            m0_address    = raddr[0];
            m1_read       = act[1] && (op[1] != 1);
            m1_write      = act[1] && (op[1] != 0);
            m1_address    = raddr[1];
            m1_writedata  = rdata[1];
            m1_byteenable = rbe[1];
        end
        chk("rnd_done_m0", 160'(done[0]), 160'(N));
        chk("rnd_done_m1", 160'(done[1]), 160'(N));
        drop_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avalon_mem_arbiter.md
Name: avalon_mem_arbiter

Overview:
- Two-master to one-slave Avalon-MM arbiter that shares the single unified CPU RAM between the MIPS instruction-fetch port (master 0, read-only) and the load/store port (master 1, read/write).
- Sits between the CPU core and the RAM in the test harness.
- Latches the winning request, issues it to the RAM, honours RAM waitrequest, and returns read data, which the RAM supplies with fixed 1-cycle latency after acceptance.
- Round-robin fairness; watchdog flags a stuck slave.

Parameters:
- TIMEOUT_CYCLES, 1024: consecutive cycles of s_waitrequest high during ISSUE before timeout_err is set.
- RR_INIT, 1: reset value of last_grant; with 1, master 0 wins the first tie.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- m0_read  input  1  instruction fetch request.
- m0_address  input  32  fetch byte address.
- m0_readdata  output  32  fetch data.
- m0_waitrequest  output  1  low for exactly the completion cycle.
- m1_read  input  1  data read request.
- m1_write  input  1  data write request.
- m1_byteenable  input  4  lane enables.
- m1_address  input  32  data byte address.
- m1_writedata  input  32  store data.
- m1_readdata  output  32  load data.
- m1_waitrequest  output  1  low for exactly the completion cycle.
- s_read  output  1  to RAM.
- s_write  output  1  to RAM.
- s_byteenable  output  4  to RAM.
- s_address  output  32  to RAM.
- s_writedata  output  32  to RAM.
- s_readdata  input  32  from RAM, valid the cycle after acceptance.
- s_waitrequest  input  1  from RAM.
- grant_owner  output  1  owner of the current transfer (0/1); debug.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky watchdog flag.

Behaviour:
- Reset (reset low, async):
  - State IDLE; last_grant=RR_INIT; watchdog counter 0.
  - Outputs: s_read=0, s_write=0, s_byteenable=0, s_address=0, s_writedata=0, m0_waitrequest=1, m1_waitrequest=1, m0/m1_readdata=0, grant_owner=0, busy=0, timeout_err=0.
  - Reset mid-transfer abandons the transfer; no completion is signalled to either master.
- Master rule: a master holds its request and all its signals stable until it sees its own waitrequest low at a rising edge.
- m1 protocol error: m1_read and m1_write both high is treated as a write.
- Master 0 requests always go to the slave with byteenable 4'b1111.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Slave strobes low; both master waitrequests high.
  - One requester: grant it. Both requesting: grant the master != last_grant.
  - On grant, at the edge: latch address/writedata/byteenable/op into registers; set owner and last_grant=owner; go to ISSUE.
- ISSUE:
  - s_* are driven from the latched registers; s_read or s_write is high.
  - If s_waitrequest=0 and op=write: owner waitrequest=0 combinationally this cycle; go to IDLE.
  - If s_waitrequest=0 and op=read: go to RESP.
  - If s_waitrequest=1: stay in ISSUE and increment the watchdog counter.
- RESP:
  - Slave strobes low; owner readdata = s_readdata; owner waitrequest=0; go to IDLE.
- Non-owner master: waitrequest=1 and readdata=0 at all times.
- Latency with no wait states:
  - Write: 2 cycles from request to completion.
  - Read: 3 cycles.
  - Each RAM wait cycle adds 1.
  - The return to IDLE costs 1 cycle between transfers.
- Watchdog:
  - Counter clears on leaving ISSUE.
  - When the counter reaches TIMEOUT_CYCLES-1 while still waiting, timeout_err is set and stays set until reset.
  - The FSM keeps waiting; the transfer is not aborted.
- Fairness: with both masters requesting continuously, grants alternate strictly 0,1,0,1,...
- Request change while not granted: a master that drops its request before being granted is simply not served.
- Request timing: requests arriving while busy are considered only in the next IDLE.

Test Plan:
- Reset release, m0_read@0xBFC00000 with the RAM holding 0x3C011234 there and no waits -> s_read=1 in cycle 2; m0_waitrequest=0 with m0_readdata=0x3C011234 in cycle 3.
- m1_write@0xBFC00010, data 0xDEADBEEF, byteenable 4'b0011 -> s_byteenable=4'b0011; a subsequent m1_read returns 0xXXXXBEEF, where the upper two bytes keep their old RAM value.
- m0 and m1 both requesting continuously for 8 transfers after reset -> grant_owner sequence 0,1,0,1,0,1,0,1; neither master is starved.
- RAM randomly asserts waitrequest -> s_address/s_writedata stay stable while waiting; each master completes exactly once per request; data matches a memory model.
- Force s_waitrequest=1 for TIMEOUT_CYCLES=16 -> timeout_err rises after 16 ISSUE cycles and stays high after waitrequest drops; the transfer then completes normally.
- Assert reset low in the ISSUE state of a read -> all outputs go to reset values immediately, with no m*_waitrequest low pulse; after release a new request is served normally.
